// File: rtl/bitcoin_hash_par.sv
`default_nettype none
// ============================================================================
//  Module   : bitcoin_hash_par
//  Purpose  : Sweeps NUM_NONCES nonces over a 19-word block header, running a
//             double SHA-256 per nonce and writing H0 of each result to memory.
//             Optional macro BITCOIN_HASH_TARGET_EN adds a target compare with
//             early exit (ports target / found / found_nonce).
//  Revision : 1.0 - initial release
// ============================================================================
module bitcoin_hash_par #(
    parameter int          NUM_NONCES  = 16,
    parameter logic [31:0] NONCE_START = 32'h0000_0000,
    parameter int          OUT_STRIDE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] message_addr,
    input  logic [15:0] output_addr,
    output logic        done,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
`ifdef BITCOIN_HASH_TARGET_EN
    ,
    input  logic [31:0] target,
    output logic        found,
    output logic [31:0] found_nonce
`endif
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] READ  = 3'd1;
    localparam logic [2:0] COMP1 = 3'd2;
    localparam logic [2:0] COMP2 = 3'd3;
    localparam logic [2:0] COMP3 = 3'd4;
    localparam logic [2:0] WRITE = 3'd5;

    localparam logic [10:0] c_LAST_IDX = 11'(NUM_NONCES - 1);
    localparam logic [15:0] c_STRIDE   = 16'(OUT_STRIDE);

    localparam logic [31:0] c_IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] c_K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    logic [2:0]  r_state;
    logic [6:0]  r_cnt;
    logic [10:0] r_idx;
    logic [15:0] r_msg_addr;
    logic [15:0] r_wr_addr;
    logic [31:0] r_nonce;
    logic [31:0] r_out;
    logic [31:0] r_hdr [0:18];
    logic [31:0] r_w   [0:15];
    logic [31:0] r_v   [0:7];
    logic [31:0] r_h   [0:7];
    logic [31:0] r_mid [0:7];

    logic [31:0] w_sum  [0:7];
    logic [31:0] w_blk2 [0:15];
    logic [31:0] w_blk3 [0:15];
    logic [31:0] w_next_nonce;
    logic [31:0] w_t1;
    logic [31:0] w_t2;
    logic [31:0] w_wnew;
    logic [4:0]  w_rd_idx;
    logic        w_hit;

    assign mem_clk = clk;
    assign done    = (r_state == IDLE);

    // Round datapath: a..h live in r_v[0..7], W_t is always r_w[0]
    assign w_t1 = r_v[7]
                + (rotr(r_v[4], 6) ^ rotr(r_v[4], 11) ^ rotr(r_v[4], 25))
                + ((r_v[4] & r_v[5]) ^ (~r_v[4] & r_v[6]))
                + c_K[r_cnt[5:0]] + r_w[0];
    assign w_t2 = (rotr(r_v[0], 2) ^ rotr(r_v[0], 13) ^ rotr(r_v[0], 22))
                + ((r_v[0] & r_v[1]) ^ (r_v[0] & r_v[2]) ^ (r_v[1] & r_v[2]));
    assign w_wnew = (rotr(r_w[14], 17) ^ rotr(r_w[14], 19) ^ (r_w[14] >> 10))
                  + r_w[9]
                  + (rotr(r_w[1], 7) ^ rotr(r_w[1], 18) ^ (r_w[1] >> 3))
                  + r_w[0];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_sum
            assign w_sum[gi] = r_h[gi] + r_v[gi];
        end
    endgenerate

    // Leaving WRITE starts the next nonce, so it must see the incremented value
    assign w_next_nonce = (r_state == WRITE) ? r_nonce + 32'd1 : r_nonce;
    assign w_rd_idx     = r_cnt[4:0] - 5'd1;

    always_comb begin
        for (int j = 0; j < 16; j++) begin
            w_blk2[j] = 32'h0;
            w_blk3[j] = 32'h0;
        end
        w_blk2[0]  = r_hdr[16];
        w_blk2[1]  = r_hdr[17];
        w_blk2[2]  = r_hdr[18];
        w_blk2[3]  = w_next_nonce;
        w_blk2[4]  = 32'h8000_0000;
        w_blk2[15] = 32'd640;
        for (int j = 0; j < 8; j++) begin
            w_blk3[j] = w_sum[j];
        end
        w_blk3[8]  = 32'h8000_0000;
        w_blk3[15] = 32'd256;
    end

`ifdef BITCOIN_HASH_TARGET_EN
    logic        r_found;
    logic [31:0] r_found_nonce;

    assign w_hit       = (r_out < target);
    assign found       = r_found;
    assign found_nonce = r_found_nonce;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_found       <= 1'b0;
            r_found_nonce <= 32'h0;
        end else if (r_state == IDLE && start) begin
            r_found       <= 1'b0;
            r_found_nonce <= 32'h0;
        end else if (r_state == WRITE && w_hit) begin
            r_found       <= 1'b1;
            r_found_nonce <= r_nonce;
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    always_comb begin
        mem_we         = 1'b0;
        mem_addr       = 16'h0;
        mem_write_data = 32'h0;
        case (r_state)
            READ: begin
                if (r_cnt <= 7'd18) begin
                    mem_addr = r_msg_addr + {9'b0, r_cnt};
                end
            end
            WRITE: begin
                mem_we         = 1'b1;
                mem_addr       = r_wr_addr;
                mem_write_data = r_out;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= 7'd0;
            r_idx      <= 11'd0;
            r_msg_addr <= 16'h0;
            r_wr_addr  <= 16'h0;
            r_nonce    <= 32'h0;
            r_out      <= 32'h0;
            for (int j = 0; j < 19; j++) r_hdr[j] <= 32'h0;
            for (int j = 0; j < 16; j++) r_w[j]   <= 32'h0;
            for (int j = 0; j < 8; j++) begin
                r_v[j]   <= 32'h0;
                r_h[j]   <= 32'h0;
                r_mid[j] <= 32'h0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_msg_addr <= message_addr;
                        r_wr_addr  <= output_addr;
                        r_nonce    <= NONCE_START;
                        r_idx      <= 11'd0;
                        r_cnt      <= 7'd0;
                        r_state    <= READ;
                    end
                end
                READ: begin
                    // Read data lags its address by one cycle
                    if (r_cnt != 7'd0) begin
                        r_hdr[w_rd_idx] <= mem_read_data;
                    end
                    if (r_cnt == 7'd19) begin
                        r_cnt   <= 7'd0;
                        r_state <= COMP1;
                        for (int j = 0; j < 8; j++) begin
                            r_h[j] <= c_IV[j];
                            r_v[j] <= c_IV[j];
                        end
                        for (int j = 0; j < 16; j++) r_w[j] <= r_hdr[j];
                    end else begin
                        r_cnt <= r_cnt + 7'd1;
                    end
                end
                COMP1, COMP2, COMP3: begin
                    if (r_cnt != 7'd64) begin
                        r_v[0] <= w_t1 + w_t2;
                        r_v[1] <= r_v[0];
                        r_v[2] <= r_v[1];
                        r_v[3] <= r_v[2];
                        r_v[4] <= r_v[3] + w_t1;
                        r_v[5] <= r_v[4];
                        r_v[6] <= r_v[5];
                        r_v[7] <= r_v[6];
                        for (int j = 0; j < 15; j++) r_w[j] <= r_w[j + 1];
                        r_w[15] <= w_wnew;
                        r_cnt   <= r_cnt + 7'd1;
                    end else begin
                        r_cnt <= 7'd0;
                        if (r_state == COMP1) begin
                            for (int j = 0; j < 8; j++) begin
                                r_mid[j] <= w_sum[j];
                                r_h[j]   <= w_sum[j];
                                r_v[j]   <= w_sum[j];
                            end
                            for (int j = 0; j < 16; j++) r_w[j] <= w_blk2[j];
                            r_state <= COMP2;
                        end else if (r_state == COMP2) begin
                            for (int j = 0; j < 8; j++) begin
                                r_h[j] <= c_IV[j];
                                r_v[j] <= c_IV[j];
                            end
                            for (int j = 0; j < 16; j++) r_w[j] <= w_blk3[j];
                            r_state <= COMP3;
                        end else begin
                            r_out   <= w_sum[0];
                            r_state <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (r_idx == c_LAST_IDX || w_hit) begin
                        r_state <= IDLE;
                    end else begin
                        r_idx     <= r_idx + 11'd1;
                        r_nonce   <= w_next_nonce;
                        r_wr_addr <= r_wr_addr + c_STRIDE;
                        for (int j = 0; j < 8; j++) begin
                            r_h[j] <= r_mid[j];
                            r_v[j] <= r_mid[j];
                        end
                        for (int j = 0; j < 16; j++) r_w[j] <= w_blk2[j];
                        r_state <= COMP2;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bitcoin_hash_par.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bitcoin_hash_par
//  Purpose  : Scoreboard bench for bitcoin_hash_par using a software SHA-256.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bitcoin_hash_par;

    localparam logic [255:0] IV_T = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [31:0] K_T [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_errors = 0;
    int n_checks = 0;

    // DUT A: default parameters
    logic        reset_a, start_a, done_a, mem_clk_a, mem_we_a;
    logic [15:0] msg_a, out_a, mem_addr_a;
    logic [31:0] mem_write_data_a, rdata_a;
    logic [31:0] target_a, found_nonce_a;
    logic        found_a;
    // DUT B: 4 nonces starting at FFFFFFFE, stride 4
    logic        reset_b, start_b, done_b, mem_clk_b, mem_we_b;
    logic [15:0] msg_b, out_b, mem_addr_b;
    logic [31:0] mem_write_data_b, rdata_b;
    logic [31:0] target_b, found_nonce_b;
    logic        found_b;

    logic [31:0] hdr_a [0:18];
    logic [31:0] hdr_b [0:18];
    logic [47:0] qa [$];
    logic [47:0] qb [$];
    int wr_cnt_a = 0;
    int wr_cnt_b = 0;

    bitcoin_hash_par u_dut_a (
        .clk(clk), .reset(reset_a), .start(start_a),
        .message_addr(msg_a), .output_addr(out_a), .done(done_a),
        .mem_clk(mem_clk_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
        .mem_write_data(mem_write_data_a), .mem_read_data(rdata_a)
`ifdef BITCOIN_HASH_TARGET_EN
        , .target(target_a), .found(found_a), .found_nonce(found_nonce_a)
`endif
    );

    bitcoin_hash_par #(.NUM_NONCES(4), .NONCE_START(32'hFFFF_FFFE), .OUT_STRIDE(4)) u_dut_b (
        .clk(clk), .reset(reset_b), .start(start_b),
        .message_addr(msg_b), .output_addr(out_b), .done(done_b),
        .mem_clk(mem_clk_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_write_data(mem_write_data_b), .mem_read_data(rdata_b)
`ifdef BITCOIN_HASH_TARGET_EN
        , .target(target_b), .found(found_b), .found_nonce(found_nonce_b)
`endif
    );

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_comp(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [0:63];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        for (int j = 0; j < 16; j++) w[j] = blk[511 - 32*j -: 32];
        for (int j = 16; j < 64; j++)
            w[j] = (rr(w[j-2], 17) ^ rr(w[j-2], 19) ^ (w[j-2] >> 10)) + w[j-7]
                 + (rr(w[j-15], 7) ^ rr(w[j-15], 18) ^ (w[j-15] >> 3)) + w[j-16];
        {a, b, c, d, e, f, g, h} = hin;
        for (int j = 0; j < 64; j++) begin
            t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + K_T[j] + w[j];
            t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {a + hin[255:224], b + hin[223:192], c + hin[191:160], d + hin[159:128],
                e + hin[127:96],  f + hin[95:64],   g + hin[63:32],   h + hin[31:0]};
    endfunction

    task automatic push_exp(input int which, input logic [15:0] oaddr, input logic [15:0] stride,
                            input logic [31:0] nstart, input int n);
        logic [31:0]  hw [0:18];
        logic [511:0] blk1;
        logic [255:0] mid, h2, h3;
        logic [31:0]  nonce;
        for (int i = 0; i < 19; i++) hw[i] = (which == 0) ? hdr_a[i] : hdr_b[i];
        for (int i = 0; i < 16; i++) blk1[511 - 32*i -: 32] = hw[i];
        mid = sha_comp(IV_T, blk1);
        for (int k = 0; k < n; k++) begin
            nonce = nstart + 32'(k);
            h2 = sha_comp(mid, {hw[16], hw[17], hw[18], nonce, 32'h8000_0000, 320'b0, 32'd640});
            h3 = sha_comp(IV_T, {h2, 32'h8000_0000, 192'b0, 32'd256});
            if (which == 0) qa.push_back({oaddr + 16'(k) * stride, h3[255:224]});
            else            qb.push_back({oaddr + 16'(k) * stride, h3[255:224]});
        end
    endtask

    task automatic wait_done(input int which, input int cyc_exp, input string tag);
        int cyc = 0;
        while (!((which == 0) ? done_a : done_b) && cyc < cyc_exp + 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check32(tag, 32'(cyc), 32'(cyc_exp));
    endtask

    // Synchronous-read memories: data appears one cycle after the address
    always @(posedge clk) begin
        logic [15:0] ia, ib;
        ia = mem_addr_a - msg_a;
        ib = mem_addr_b - msg_b;
        rdata_a <= (ia < 16'd19) ? hdr_a[ia[4:0]] : 32'hDEAD_BEEF;
        rdata_b <= (ib < 16'd19) ? hdr_b[ib[4:0]] : 32'hDEAD_BEEF;
    end

    always @(negedge clk) begin
        logic [47:0] e;
        if (mem_we_a) begin
            wr_cnt_a++;
            check32("wr_pending_a", 32'(qa.size() > 0), 32'd1);
            if (qa.size() > 0) begin
                e = qa.pop_front();
                check32("wr_addr_a", {16'h0, mem_addr_a}, {16'h0, e[47:32]});
                check32("wr_data_a", mem_write_data_a, e[31:0]);
            end
        end
        if (mem_we_b) begin
            wr_cnt_b++;
            check32("wr_pending_b", 32'(qb.size() > 0), 32'd1);
            if (qb.size() > 0) begin
                e = qb.pop_front();
                check32("wr_addr_b", {16'h0, mem_addr_b}, {16'h0, e[47:32]});
                check32("wr_data_b", mem_write_data_b, e[31:0]);
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int snap;
        int guard;
        reset_a = 1'b1; reset_b = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        msg_a = 16'h0000; out_a = 16'h0100;
        msg_b = 16'hFFFE; out_b = 16'hFFF8;
        target_a = 32'h0; target_b = 32'h0;
        for (int i = 0; i < 19; i++) begin
            hdr_a[i] = 32'h0101_0101 * i;
            hdr_b[i] = $urandom;
        end
        repeat (3) @(posedge clk);
        #1;
        check32("rst_done", {31'b0, done_a}, 32'd1);
        check32("rst_we", {31'b0, mem_we_a}, 32'd0);
        check32("rst_addr", {16'h0, mem_addr_a}, 32'd0);
        check32("rst_wdata", mem_write_data_a, 32'd0);
        @(negedge clk);
        reset_a = 1'b0; reset_b = 1'b0;

        // Default sweep of 16 nonces
        push_exp(0, 16'h0100, 16'd1, 32'h0, 16);
        @(negedge clk); start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        check32("busy_a", {31'b0, done_a}, 32'd0);
        wait_done(0, 2181, "done_lat_a");
        check32("q_empty_a", 32'(qa.size()), 32'd0);

        // Nonce wrap, address wrap, start held through done
        push_exp(1, 16'hFFF8, 16'd4, 32'hFFFF_FFFE, 4);
        push_exp(1, 16'hFFF8, 16'd4, 32'hFFFF_FFFE, 4);
        @(negedge clk); start_b = 1'b1;
        @(posedge clk); #1;
        wait_done(1, 609, "done_lat_b1");
        @(posedge clk); #1;
        check32("restart_b", {31'b0, done_b}, 32'd0);
        start_b = 1'b0;
        wait_done(1, 609, "done_lat_b2");
        check32("q_empty_b", 32'(qb.size()), 32'd0);
        check32("wr_cnt_b", 32'(wr_cnt_b), 32'd8);

        // Reset during COMP2 of nonce 5
        snap = wr_cnt_a;
        push_exp(0, 16'h0100, 16'd1, 32'h0, 16);
        @(negedge clk); start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        guard = 0;
        while (wr_cnt_a < snap + 5 && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
        check32("reach_n5", 32'(wr_cnt_a - snap), 32'd5);
        repeat (30) @(posedge clk);
        @(negedge clk); reset_a = 1'b1;
        qa.delete();
        #1;
        check32("mid_rst_done", {31'b0, done_a}, 32'd1);
        check32("mid_rst_we", {31'b0, mem_we_a}, 32'd0);
        @(negedge clk); reset_a = 1'b0;
        snap = wr_cnt_a;
        repeat (300) @(posedge clk);
        #1;
        check32("no_wr_after_rst", 32'(wr_cnt_a), 32'(snap));
        check32("idle_after_rst", {31'b0, done_a}, 32'd1);
        push_exp(0, 16'h0100, 16'd1, 32'h0, 16);
        @(negedge clk); start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        wait_done(0, 2181, "done_lat_a2");
        check32("q_empty_a2", 32'(qa.size()), 32'd0);
        check32("wr_cnt_a2", 32'(wr_cnt_a - snap), 32'd16);

`ifdef BITCOIN_HASH_TARGET_EN
        target_a = 32'hFFFF_FFFF;
        snap = wr_cnt_a;
        push_exp(0, 16'h0100, 16'd1, 32'h0, 1);
        @(negedge clk); start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        wait_done(0, 216, "done_lat_found");
        check32("found", {31'b0, found_a}, 32'd1);
        check32("found_nonce", found_nonce_a, 32'h0);
        repeat (5) @(posedge clk);
        #1;
        check32("found_hold", {31'b0, found_a}, 32'd1);
        check32("found_wr_cnt", 32'(wr_cnt_a - snap), 32'd1);
        target_a = 32'h0;
        push_exp(0, 16'h0100, 16'd1, 32'h0, 16);
        @(negedge clk); start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        check32("found_clear", {31'b0, found_a}, 32'd0);
        wait_done(0, 2181, "done_lat_a3");
        check32("q_empty_a3", 32'(qa.size()), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bitcoin_hash_par.md
BITCOIN_HASH_PAR -- requirements
Module: bitcoin_hash_par

Interface
REQ-001 SHALL have parameter NUM_NONCES, default 16, range 1..1024: number of nonces swept per start.
REQ-002 SHALL have parameter NONCE_START, default 0: 32-bit value of the first nonce.
REQ-003 SHALL have parameter OUT_STRIDE, default 1, range 1..8: address step between consecutive result words.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state is updated on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: begins a run when sampled high in IDLE.
REQ-007 SHALL have port message_addr, input, 16 bits: base address of the 19-word block header.
REQ-008 SHALL have port output_addr, input, 16 bits: base address of the result words.
REQ-009 SHALL have port done, output, 1 bit: high exactly while in IDLE.
REQ-010 SHALL have port mem_clk, output, 1 bit: equal to clk.
REQ-011 SHALL have port mem_we, output, 1 bit: memory write enable.
REQ-012 SHALL have port mem_addr, output, 16 bits: memory address.
REQ-013 SHALL have port mem_write_data, output, 32 bits: memory write data.
REQ-014 SHALL have port mem_read_data, input, 32 bits: memory read data, valid one cycle after its address is presented.

Function
REQ-015 SHALL use FSM states IDLE, READ, COMP1, COMP2, COMP3, WRITE.
REQ-016 Transitions SHALL be: IDLE->READ on start; READ->COMP1; COMP1->COMP2; COMP2->COMP3; COMP3->WRITE; WRITE->COMP2 for the next nonce, or WRITE->IDLE after the last nonce.
REQ-017 In IDLE, start SHALL latch message_addr and output_addr; start SHALL be ignored in every other state.
REQ-018 READ SHALL present addresses message_addr+0 .. message_addr+18, one per cycle, and capture the word returned one cycle later; READ SHALL last exactly 20 cycles.
REQ-019 Every compression SHALL be the standard SHA-256 compression, one round per cycle, with an on-the-fly 16-word message schedule; it SHALL take 64 round cycles plus 1 cycle for the final add, 65 cycles in total.
REQ-020 COMP1 SHALL compress header words 0..15 from the SHA-256 IV; the resulting midstate SHALL be computed once per run.
REQ-021 COMP2 SHALL compress, from the midstate, this block: header words 16..18, the nonce, 32'h80000000, ten zero words, then 32'd640.
REQ-022 COMP3 SHALL compress, from the SHA-256 IV, this block: the 8 COMP2 output words, 32'h80000000, six zero words, then 32'd256.
REQ-023 For nonce index n, the nonce value SHALL be NONCE_START+n, computed modulo 2^32.
REQ-024 WRITE SHALL last 1 cycle with mem_we=1, mem_addr=output_addr+n*OUT_STRIDE (mod 2^16) and mem_write_data=H0 of COMP3.
REQ-025 mem_we SHALL be 0 in every state other than WRITE.
REQ-026 All additions SHALL be modulo 2^32; address arithmetic SHALL wrap at 16 bits.
REQ-027 From the start-sampling edge to done rising SHALL take exactly 20+65+NUM_NONCES*131 cycles.

Reset
REQ-028 While reset is high: state=IDLE, done=1, mem_we=0, mem_addr=0, mem_write_data=0, and the nonce counter and all hash registers SHALL be 0.
REQ-029 Reset asserted mid-run SHALL abort the run immediately, with no further memory write; the first start after reset is released SHALL begin a fresh run.

Configuration
REQ-030 With macro BITCOIN_HASH_TARGET_EN defined, ports target (input, 32 bits), found (output, 1 bit) and found_nonce (output, 32 bits) SHALL exist.
REQ-031 With BITCOIN_HASH_TARGET_EN defined, after a WRITE whose H0 is less than target (unsigned): the block SHALL set found=1, set found_nonce to that nonce, and go to IDLE, skipping the remaining nonces.
REQ-032 With BITCOIN_HASH_TARGET_EN defined, found and found_nonce SHALL reset to 0, clear on start, and hold their value in IDLE.
REQ-033 Without BITCOIN_HASH_TARGET_EN, these three ports and the early exit SHALL be absent, and all NUM_NONCES nonces SHALL be processed.

Verification
REQ-034 Default parameters, header words i = 32'h01010101*i, message_addr=0, output_addr=16'h0100 -> 16 writes to 0x0100..0x010F; each word SHALL match the software model; done SHALL rise after 2181 cycles.
REQ-035 NUM_NONCES=3, NONCE_START=32'hFFFFFFFF -> the nonces used SHALL be FFFFFFFF, 0, 1 (wrap).
REQ-036 OUT_STRIDE=4, output_addr=16'hFFF8, NUM_NONCES=4 -> writes SHALL go to FFF8, FFFC, 0000, 0004.
REQ-037 Reset pulsed during COMP2 of nonce 5 -> no write SHALL occur after the pulse; done=1; a following start SHALL produce the full correct 16 results.
REQ-038 BITCOIN_HASH_TARGET_EN defined, target=32'hFFFFFFFF -> exactly 1 write; found=1; found_nonce=NONCE_START; done after 20+65+131 cycles.
REQ-039 start held high for the whole run, including at done -> a second run SHALL begin only from IDLE; pulses of start mid-run SHALL have no effect.
